// File: rtl/vmem_writer.sv
// Frame-buffer write producer: turns a raster-ordered RGB pixel stream into
// one-cycle-latency memory writes, and can fill the whole frame with one colour.
module vmem_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        clear_req,
  input  logic [23:0] clear_color,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [23:0] mem_wdata,
  output logic        busy,
  output logic        frame_done,
  output logic        clear_done,
  output logic        sof_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  logic [1:0]  state;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [23:0] fill_color;

  logic        accept;
  logic        clear_go;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [9:0]  next_x;
  logic [8:0]  next_y;
  logic        last_x;
  logic        last_pix;

  assign s_ready  = (state != S_CLEAR) && !clear_req && !rst;
  assign accept   = s_valid && s_ready;
  assign clear_go = clear_req && (state != S_CLEAR);
  assign busy     = (state == S_CLEAR);

  // Position of the pixel written this cycle and where the raster goes next.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pos_x = x;
    pos_y = y;
    if (clear_go || (accept && s_sof)) begin
      pos_x = '0;
      pos_y = '0;
    end
    last_x   = (pos_x == X_LAST);
    last_pix = last_x && (pos_y == Y_LAST);
    next_x   = last_x ? '0 : pos_x + 10'd1;
    next_y   = pos_y;
    if (last_pix)
      next_y = '0;
    else if (last_x)
      next_y = pos_y + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      fill_color <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
      sof_err    <= 1'b0;

      if (state == S_CLEAR) begin
        // clear_done is visible with the final write; leave CLEAR one cycle later.
        if (clear_done) begin
          state <= S_IDLE;
        end else begin
          mem_we     <= 1'b1;
          mem_addr   <= {pos_x, pos_y};
          mem_wdata  <= fill_color;
          x          <= next_x;
          y          <= next_y;
          clear_done <= last_pix;
        end
      end else if (clear_go) begin
        state      <= S_CLEAR;
        fill_color <= clear_color;
        mem_we     <= 1'b1;
        mem_addr   <= {pos_x, pos_y};
        mem_wdata  <= clear_color;
        x          <= next_x;
        y          <= next_y;
        clear_done <= last_pix;
      end else if (accept) begin
        mem_we     <= 1'b1;
        mem_addr   <= {pos_x, pos_y};
        mem_wdata  <= s_data;
        sof_err    <= s_sof && ((x != '0) || (y != '0));
        frame_done <= last_pix;
        x          <= next_x;
        y          <= next_y;
        state      <= last_pix ? S_IDLE : S_STREAM;
      end
    end
  end

endmodule

// File: doc/vmem_writer.md
Name: vmem_writer

Overview:
- Write-side producer for the VGA frame buffer. Consumes a raster-ordered 24-bit RGB pixel stream over a valid/ready handshake and generates frame-buffer write cycles.
- Address format matches what the VGA scan-out side reads: {h[9:0], v[8:0]}, 19 bits.
- Also provides a hardware clear that fills the whole active frame with one colour.
- Sits between a pixel source (CPU/DMA/pattern generator) and the write port of the dual-port video memory.

Parameters:
- H_ACTIVE, 640, active pixels per line; x counts 0..H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; y counts 0..V_ACTIVE-1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  1  pixel beat valid.
- s_ready  output  1  block can accept a beat this cycle.
- s_data  input  24  pixel, {R[7:0], G[7:0], B[7:0]}.
- s_sof  input  1  start of frame; qualifies the accepted beat as pixel (0,0).
- clear_req  input  1  single-cycle request to fill the frame with clear_color.
- clear_color  input  24  fill colour, sampled in the cycle clear_req is honoured.
- mem_we  output  1  write enable to the frame buffer.
- mem_addr  output  19  write address, {x[9:0], y[8:0]}.
- mem_wdata  output  24  write data.
- busy  output  1  high while a clear is in progress.
- frame_done  output  1  one-cycle pulse coincident with the write of pixel (H_ACTIVE-1, V_ACTIVE-1).
- clear_done  output  1  one-cycle pulse coincident with the last clear write.
- sof_err  output  1  one-cycle pulse: s_sof was accepted while position was not (0,0).

Behaviour:
- Reset:
  - State IDLE; x=0, y=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, clear_done=0, sof_err=0.
  - s_ready=0 while rst is high.
- States:
  - IDLE: position is (0,0) and no frame is in progress.
  - STREAM: a frame is partially written.
  - CLEAR: fill in progress.
- s_ready is combinational: (state != CLEAR) && !clear_req && !rst.
- Accept = s_valid && s_ready. The pixel is written at the current (x,y), or at (0,0) if s_sof=1.
  - s_sof in STREAM with (x,y) != (0,0) pulses sof_err in the same cycle the write appears, then the frame restarts from (0,0).
- Write latency is exactly 1 cycle: an accept in cycle N drives mem_we=1 with mem_addr={x,y[8:0]} and mem_wdata=s_data in cycle N+1. mem_we=0 in every cycle with no accept and no clear write.
- Position update after each written pixel:
  - x+1.
  - At x=H_ACTIVE-1: x=0, y+1.
  - At (H_ACTIVE-1, V_ACTIVE-1): x=0, y=0, frame_done pulses together with that write, state -> IDLE.
  - The first accept in IDLE moves the state to STREAM, unless it completes the frame, which is only possible when H_ACTIVE=V_ACTIVE=1.
- Clear:
  - clear_req is honoured in IDLE or STREAM. A partially written frame is abandoned.
  - Latch clear_color, set x=y=0, go to CLEAR; busy=1 from the next cycle.
  - One write per cycle in raster order: H_ACTIVE*V_ACTIVE writes, 307200 by default.
  - The first clear write appears 1 cycle after clear_req.
  - clear_done pulses with the final write. The cycle after that, state=IDLE, busy=0, s_ready=1.
  - clear_req during CLEAR is ignored; the clear does not restart.
- Simultaneous clear_req and s_valid: clear wins. s_ready=0, so the beat is not accepted; the source must hold it.
- Holding s_valid with s_ready=0: no write and no position change. Data is taken only on accept.
- Reset mid-frame or mid-clear: in the cycle after rst, all outputs are at their reset values. Any pending registered write is dropped, not completed.
- Widths: x is 10 bits, y is 9 bits. mem_addr upper bits are x, lower bits are y. Unused address space beyond H_ACTIVE/V_ACTIVE is never written.

Test Plan:
- Reset, then stream 3 beats (s_sof=1 on the first) with data 0xFF0000, 0x00FF00, 0x0000FF -> writes at addr 0x00000, 0x00200, 0x00400, one cycle after each accept, with matching data.
- Stream a full 640x480 frame of counting data -> exactly 307200 writes. The last write has addr {10'd639, 9'd479} = 0x4FFDF. frame_done pulses once with it. The next beat writes addr 0.
- Stream to (5,0), then a beat with s_sof=1 -> sof_err pulses, that pixel is written at addr 0, and the following beat goes to addr 0x00200.
- clear_req with clear_color=0x123456 while s_valid=1 mid-frame -> s_ready=0 that cycle. Then 307200 consecutive writes of 0x123456, busy=1 throughout, and clear_done with the write to 0x4FFDF. The held beat is accepted afterwards and written to addr 0.
- Toggle s_valid randomly with a constant s_sof=0 stream -> writes only occur the cycle after accepts, and addresses stay contiguous in raster order.
- Assert rst for 1 cycle mid-clear -> the next cycle shows mem_we=0, busy=0, and s_ready=1 after rst drops. The next accepted beat writes addr 0.
